// File: rtl/kanagawa_hal_mcfifo_pkg.sv
// Shared helpers for the multichannel FIFO: width derivation, explicit pointer
// wrap and circular first-set-bit search used by the read arbiter.
package kanagawa_hal_mcfifo_pkg;

  localparam int unsigned MAX_CHANNELS = 32;
  localparam int unsigned MAX_IDX_W    = 5;

  function automatic int unsigned chan_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // DEPTH need not be a power of two, so wrap is an explicit compare.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

  function automatic int unsigned rr_pick(input logic [MAX_CHANNELS-1:0] vec,
                                          input int unsigned start,
                                          input int unsigned n);
    int unsigned idx;
    logic        found;
    rr_pick = 0;
    found   = 1'b0;
    for (int unsigned i = 0; i < MAX_CHANNELS; i++) begin
      if (i < n && !found) begin
        idx = (start + i) % n;
        if (vec[idx[MAX_IDX_W-1:0]]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/kanagawa_hal_rr_arbiter.sv
// Read-side channel selector. Round-robin from rr_q by default; with
// KANAGAWA_MCFIFO_STRICT_PRIORITY_EN defined, lowest non-empty index wins.
module kanagawa_hal_rr_arbiter
  import kanagawa_hal_mcfifo_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CHAN_W   = chan_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] req_i,
  input  logic                accept_i,
  output logic                valid_o,
  output logic [CHAN_W-1:0]   grant_o
);

  logic [MAX_CHANNELS-1:0] req_ext;

  assign req_ext = MAX_CHANNELS'(req_i);
  assign valid_o = |req_i;

`ifdef KANAGAWA_MCFIFO_STRICT_PRIORITY_EN
  logic unused_ok;
  assign unused_ok = ^{clk, rst, accept_i};
  assign grant_o   = CHAN_W'(rr_pick(req_ext, 0, CHANNELS));
`else
  logic [CHAN_W-1:0] rr_q;

  assign grant_o = CHAN_W'(rr_pick(req_ext, 32'(rr_q), CHANNELS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= '0;
    end else if (accept_i) begin
      rr_q <= (grant_o == CHAN_W'(CHANNELS - 1)) ? '0 : grant_o + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/kanagawa_hal_multichannel_fifo.sv
// CHANNELS logical ready/valid queues partitioned statically in one shared array.
// Define KANAGAWA_MCFIFO_STRICT_PRIORITY_EN for fixed-priority read selection.
module kanagawa_hal_multichannel_fifo
  import kanagawa_hal_mcfifo_pkg::*;
#(
  parameter int CHANNELS           = 4,
  parameter int CHAN_W             = chan_width(CHANNELS),
  parameter int DEPTH              = 6,
  parameter int CNT_W              = cnt_width(DEPTH),
  parameter int WIDTH              = 32,
  parameter int ALMOSTFULL_ENTRIES = 1,
  parameter int USE_LUTRAM         = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      input_valid,
  output logic                      input_ready,
  input  logic [CHAN_W-1:0]         input_chan,
  input  logic [WIDTH-1:0]          input_data,
  output logic                      output_valid,
  input  logic                      output_ready,
  output logic [CHAN_W-1:0]         output_chan,
  output logic [WIDTH-1:0]          output_data,
  output logic [CHANNELS*CNT_W-1:0] chan_usedw,
  output logic [CHANNELS-1:0]       chan_almost_full,
  output logic [CHANNELS-1:0]       chan_full
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int ADDR_W = $clog2(CHANNELS * DEPTH);

  if (USE_LUTRAM == 0) begin : g_bad_cfg
    $error("kanagawa_hal_multichannel_fifo: USE_LUTRAM=0 is not supported");
  end

  logic [WIDTH-1:0] mem_q [CHANNELS*DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [CHANNELS];
  logic [PTR_W-1:0] wr_ptr_d [CHANNELS];
  logic [PTR_W-1:0] rd_ptr_q [CHANNELS];
  logic [PTR_W-1:0] rd_ptr_d [CHANNELS];
  logic [CNT_W-1:0] count_q  [CHANNELS];
  logic [CNT_W-1:0] count_d  [CHANNELS];

  logic [CHANNELS-1:0] not_empty;
  logic [CHAN_W-1:0]   sel;
  logic                wr_en;
  logic                rd_en;
  logic                full_sel;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ADDR_W-1:0]   rd_addr;

  kanagawa_hal_rr_arbiter #(
    .CHANNELS (CHANNELS),
    .CHAN_W   (CHAN_W)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (not_empty),
    .accept_i (rd_en),
    .valid_o  (output_valid),
    .grant_o  (sel)
  );

  always_comb begin
    not_empty = '0;
    full_sel  = 1'b0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      not_empty[c]                  = (count_q[c] != '0);
      chan_full[c]                  = (32'(count_q[c]) == DEPTH);
      // Threshold may be <= 0, so compare with the margin on the count side.
      chan_almost_full[c]           = (32'(count_q[c]) + ALMOSTFULL_ENTRIES >= DEPTH);
      chan_usedw[c*CNT_W +: CNT_W]  = count_q[c];
      if (input_chan == CHAN_W'(c)) full_sel = chan_full[c];
    end
  end

  assign input_ready = ~rst & ~full_sel;
  assign wr_en       = input_valid & input_ready;
  assign rd_en       = output_valid & output_ready;
  assign output_chan = sel;
  assign wr_addr     = ADDR_W'(32'(input_chan) * DEPTH + 32'(wr_ptr_q[input_chan]));
  assign rd_addr     = ADDR_W'(32'(sel) * DEPTH + 32'(rd_ptr_q[sel]));
  assign output_data = mem_q[rd_addr];

  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      logic wr_c;
      logic rd_c;
      wr_c        = wr_en && (input_chan == CHAN_W'(c));
      rd_c        = rd_en && (sel == CHAN_W'(c));
      wr_ptr_d[c] = wr_c ? PTR_W'(next_ptr(32'(wr_ptr_q[c]), DEPTH)) : wr_ptr_q[c];
      rd_ptr_d[c] = rd_c ? PTR_W'(next_ptr(32'(rd_ptr_q[c]), DEPTH)) : rd_ptr_q[c];
      count_d[c]  = count_q[c] + CNT_W'(wr_c) - CNT_W'(rd_c);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        count_q[c]  <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        count_q[c]  <= count_d[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= input_data;
  end

endmodule

// File: tb/tb_kanagawa_hal_multichannel_fifo.sv
// Scoreboard bench for kanagawa_hal_multichannel_fifo (default build, round-robin).
module tb_kanagawa_hal_multichannel_fifo;

  localparam int NCH   = 4;
  localparam int CW    = 2;
  localparam int DEPTH = 6;
  localparam int CNTW  = 3;
  localparam int W     = 32;
  localparam int AFE   = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            input_valid;
  logic            input_ready;
  logic [CW-1:0]   input_chan;
  logic [W-1:0]    input_data;
  logic            output_valid;
  logic            output_ready;
  logic [CW-1:0]   output_chan;
  logic [W-1:0]    output_data;
  logic [NCH*CNTW-1:0] chan_usedw;
  logic [NCH-1:0]  chan_almost_full;
  logic [NCH-1:0]  chan_full;

  int n_checks = 0;
  int n_fail   = 0;
  int seq      = 0;
  int rr       = 0;
  logic [W-1:0] sbq [NCH][$];

  always #5 clk = ~clk;

  kanagawa_hal_multichannel_fifo #(
    .CHANNELS           (NCH),
    .DEPTH              (DEPTH),
    .WIDTH              (W),
    .ALMOSTFULL_ENTRIES (AFE),
    .USE_LUTRAM         (1)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .input_valid      (input_valid),
    .input_ready      (input_ready),
    .input_chan       (input_chan),
    .input_data       (input_data),
    .output_valid     (output_valid),
    .output_ready     (output_ready),
    .output_chan      (output_chan),
    .output_data      (output_data),
    .chan_usedw       (chan_usedw),
    .chan_almost_full (chan_almost_full),
    .chan_full        (chan_full)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_sel();
    for (int i = 0; i < NCH; i++) begin
`ifdef KANAGAWA_MCFIFO_STRICT_PRIORITY_EN
      int idx = i;
`else
      int idx = (rr + i) % NCH;
`endif
      if (sbq[idx].size() > 0) return idx;
    end
    return 0;
  endfunction

  function automatic logic [W-1:0] nd(input int ch);
    seq++;
    return {8'(ch + 8'hA0), 24'(seq)};
  endfunction

  // Called at posedge+1; checks before the next edge, then advances the model.
  task automatic step(input logic v, input int ch, input logic [W-1:0] d, input logic ordy);
    logic exp_valid;
    logic exp_ready;
    int   s;
    input_valid  = v;
    input_chan   = CW'(ch);
    input_data   = d;
    output_ready = ordy;
    #3;
    exp_valid = 1'b0;
    for (int c = 0; c < NCH; c++) if (sbq[c].size() > 0) exp_valid = 1'b1;
    s         = model_sel();
    exp_ready = (sbq[ch].size() < DEPTH);
    check("input_ready", 64'(input_ready), 64'(exp_ready));
    check("output_valid", 64'(output_valid), 64'(exp_valid));
    if (exp_valid) begin
      check("output_chan", 64'(output_chan), 64'(s));
      check("output_data", 64'(output_data), 64'(sbq[s][0]));
    end
    for (int c = 0; c < NCH; c++) begin
      logic [CNTW-1:0] u;
      u = chan_usedw[c*CNTW +: CNTW];
      check("chan_usedw", 64'(u), 64'(sbq[c].size()));
      check("chan_full", 64'(chan_full[c]), 64'(sbq[c].size() == DEPTH));
      check("chan_almost_full", 64'(chan_almost_full[c]), 64'(sbq[c].size() >= DEPTH - AFE));
    end
    if (exp_valid && ordy) begin
      void'(sbq[s].pop_front());
      rr = (s + 1) % NCH;
    end
    if (v && exp_ready) sbq[ch].push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_check();
    for (int c = 0; c < NCH; c++) begin
      input_chan = CW'(c);
      #1;
      check("rst_input_ready", 64'(input_ready), 64'd0);
    end
    check("rst_output_valid", 64'(output_valid), 64'd0);
    check("rst_output_chan", 64'(output_chan), 64'd0);
    check("rst_usedw", 64'(chan_usedw), 64'd0);
    check("rst_full", 64'(chan_full), 64'd0);
    check("rst_almost_full", 64'(chan_almost_full), 64'd0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, '0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; input_valid = 1'b0; input_chan = '0; input_data = '0; output_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_check();
    @(posedge clk); #1;
    rst = 1'b0;

    for (int c = 0; c < NCH; c++) step(1'b0, c, '0, 1'b0);

    // Fill channel 2 past full; the 7th beat must be refused.
    for (int i = 0; i < 7; i++) step(1'b1, 2, nd(2), 1'b0);
    step(1'b0, 0, '0, 1'b0);
    drain(8);

    // Channel 1 stream while draining, crossing the pointer wrap.
    for (int i = 0; i < 8; i++) step(1'b1, 1, nd(1), 1'b1);
    drain(3);

    // Round-robin over channels 0,1,3.
    for (int i = 0; i < 2; i++) step(1'b1, 0, nd(0), 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 1, nd(1), 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 3, nd(3), 1'b0);
    drain(7);

    // Simultaneous write/read on channel 0 holding 3 entries.
    for (int i = 0; i < 3; i++) step(1'b1, 0, nd(0), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 0, nd(0), 1'b1);
    drain(5);

    // Write into empty channel 2 with the consumer ready.
    step(1'b1, 2, nd(2), 1'b1);
    drain(2);

    for (int i = 0; i < 300; i++) begin
      int ch;
      ch = int'($urandom_range(NCH - 1, 0));
      step(1'($urandom_range(1, 0)), ch, nd(ch), 1'($urandom_range(1, 0)));
    end
    drain(30);

    // Mid-stream reset with channels 0 and 2 partially full.
    for (int i = 0; i < 3; i++) step(1'b1, 0, nd(0), 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 2, nd(2), 1'b0);
    input_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    reset_check();
    for (int c = 0; c < NCH; c++) sbq[c].delete();
    rr = 0;
    input_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < NCH; c++) step(1'b0, c, '0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1, nd(1), 1'b0);
    step(1'b1, 2, nd(2), 1'b1);
    drain(8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
